// File: rtl/serial_adder_ctrl_pkg.sv
// serial_adder_ctrl_pkg: shared types for the bit-serial adder controller.
// Holds the FSM state enum, requester IDs and the round-robin pick helper.
package serial_adder_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic REQ_ID0 = 1'b0;
  localparam logic REQ_ID1 = 1'b1;

  // Both valid: the one not granted last wins.
  // One valid: that one wins (v1 alone -> 1, else 0).
  function automatic logic rr_pick(
    input logic v0,
    input logic v1,
    input logic last
  );
    if (v0 && v1) return ~last;
    return v1 ? REQ_ID1 : REQ_ID0;
  endfunction

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// serial_adder_ctrl_if: requester/result handshake bundle.
// Names are from the controller's view; slave = controller, master = driver.
// With SERIAL_ADDER_CTRL_SUB_EN defined, per-requester SUB flags are added.
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             i_REQ0_VALID;
  logic             i_REQ1_VALID;
  logic             o_REQ0_READY;
  logic             o_REQ1_READY;
  logic [WIDTH-1:0] i_REQ0_A;
  logic [WIDTH-1:0] i_REQ0_B;
  logic [WIDTH-1:0] i_REQ1_A;
  logic [WIDTH-1:0] i_REQ1_B;
  logic             i_REQ0_CIN;
  logic             i_REQ1_CIN;
`ifdef SERIAL_ADDER_CTRL_SUB_EN
  logic             i_REQ0_SUB;
  logic             i_REQ1_SUB;
`endif
  logic             o_RES_VALID;
  logic             i_RES_READY;
  logic [WIDTH-1:0] o_RES_S;
  logic             o_RES_COUT;
  logic             o_RES_ID;
  logic             o_BUSY;

  modport slave (
    input  i_REQ0_VALID, i_REQ1_VALID,
    input  i_REQ0_A, i_REQ0_B,
    input  i_REQ1_A, i_REQ1_B,
    input  i_REQ0_CIN, i_REQ1_CIN,
`ifdef SERIAL_ADDER_CTRL_SUB_EN
    input  i_REQ0_SUB, i_REQ1_SUB,
`endif
    input  i_RES_READY,
    output o_REQ0_READY, o_REQ1_READY,
    output o_RES_VALID, o_RES_S,
    output o_RES_COUT, o_RES_ID,
    output o_BUSY
  );

  modport master (
    output i_REQ0_VALID, i_REQ1_VALID,
    output i_REQ0_A, i_REQ0_B,
    output i_REQ1_A, i_REQ1_B,
    output i_REQ0_CIN, i_REQ1_CIN,
`ifdef SERIAL_ADDER_CTRL_SUB_EN
    output i_REQ0_SUB, i_REQ1_SUB,
`endif
    output i_RES_READY,
    input  o_REQ0_READY, o_REQ1_READY,
    input  o_RES_VALID, o_RES_S,
    input  o_RES_COUT, o_RES_ID,
    input  o_BUSY
  );

endinterface

// File: rtl/serial_adder_ctrl_fa.sv
// serial_adder_ctrl_fa: 1-bit full-adder cell.
// Ports: i_A, i_B, i_CIN -> o_S (sum), o_COUT (carry).
module serial_adder_ctrl_fa (
  input  logic i_A,
  input  logic i_B,
  input  logic i_CIN,
  output logic o_S,
  output logic o_COUT
);

  logic w_p;

  assign w_p    = i_A ^ i_B;
  assign o_S    = w_p ^ i_CIN;
  assign o_COUT = (i_A & i_B) | (i_CIN & w_p);

endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: two-requester bit-serial adder, one FA cell, LSB first.
// Ports: i_EMUCLK, i_MRST_n (async, active-low), bus (serial_adder_ctrl_if.slave).
// Optional SERIAL_ADDER_CTRL_SUB_EN adds A-B via A+~B+1 (COUT=1 means no borrow).
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                 i_EMUCLK,
  input  logic                 i_MRST_n,
  serial_adder_ctrl_if.slave   bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           r_state;
  state_e           w_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_id;
  logic             r_last;

  logic             w_gnt;
  logic             w_accept;
  logic             w_rdy0;
  logic             w_rdy1;
  logic             w_s;
  logic             w_c;
  logic [WIDTH-1:0] w_sel_a;
  logic [WIDTH-1:0] w_sel_b;
  logic             w_sel_cin;

  assign w_gnt = rr_pick(bus.i_REQ0_VALID,
                         bus.i_REQ1_VALID,
                         r_last);

  assign w_sel_a = w_gnt ? bus.i_REQ1_A : bus.i_REQ0_A;

`ifdef SERIAL_ADDER_CTRL_SUB_EN
  logic             w_sel_sub;
  logic [WIDTH-1:0] w_raw_b;

  assign w_sel_sub = w_gnt ? bus.i_REQ1_SUB : bus.i_REQ0_SUB;
  assign w_raw_b   = w_gnt ? bus.i_REQ1_B : bus.i_REQ0_B;
  // Subtract: invert B once at latch time, force the +1 via carry-in.
  assign w_sel_b   = w_sel_sub ? ~w_raw_b : w_raw_b;
  assign w_sel_cin = w_sel_sub ? 1'b1
                   : (w_gnt ? bus.i_REQ1_CIN : bus.i_REQ0_CIN);
`else
  assign w_sel_b   = w_gnt ? bus.i_REQ1_B : bus.i_REQ0_B;
  assign w_sel_cin = w_gnt ? bus.i_REQ1_CIN : bus.i_REQ0_CIN;
`endif

  serial_adder_ctrl_fa u_fa (
    .i_A    (r_a[0]),
    .i_B    (r_b[0]),
    .i_CIN  (r_carry),
    .o_S    (w_s),
    .o_COUT (w_c)
  );

  always_ff @(posedge i_EMUCLK or negedge i_MRST_n) begin
    if (!i_MRST_n) r_state <= IDLE;
    else           r_state <= w_next;
  end

  // READY is gated by reset so every output reads 0 while reset is held.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_rdy0   = 1'b0;
    w_rdy1   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (i_MRST_n && (bus.i_REQ0_VALID || bus.i_REQ1_VALID)) begin
          w_accept = 1'b1;
          w_rdy0   = (w_gnt == REQ_ID0);
          w_rdy1   = (w_gnt == REQ_ID1);
          w_next   = SHIFT;
        end
      end
      SHIFT: begin
        if (r_cnt == LAST) w_next = DONE;
      end
      DONE: begin
        if (bus.i_RES_READY) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // r_sum is not cleared on accept: all WIDTH bits get overwritten by the
  // shifts, and it keeps the previous result visible until then.
  always_ff @(posedge i_EMUCLK or negedge i_MRST_n) begin
    if (!i_MRST_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_id    <= 1'b0;
      r_last  <= 1'b1;
    end else if (w_accept) begin
      r_a     <= w_sel_a;
      r_b     <= w_sel_b;
      r_carry <= w_sel_cin;
      r_id    <= w_gnt;
      r_last  <= w_gnt;
      r_cnt   <= '0;
    end else if (r_state == SHIFT) begin
      r_sum   <= {w_s, r_sum[WIDTH-1:1]};
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_carry <= w_c;
      r_cnt   <= r_cnt + CW'(1);
    end
  end

  assign bus.o_REQ0_READY = w_rdy0;
  assign bus.o_REQ1_READY = w_rdy1;
  assign bus.o_RES_VALID  = (r_state == DONE);
  assign bus.o_BUSY       = (r_state != IDLE);
  assign bus.o_RES_S      = r_sum;
  assign bus.o_RES_COUT   = r_carry;
  assign bus.o_RES_ID     = r_id;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: directed vector table plus multi-cycle sequences
// (round-robin, result stall, mid-shift reset) for serial_adder_ctrl.
module tb_serial_adder_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_pass = 0;
  int   n_tot = 0;

  serial_adder_ctrl_if #(.WIDTH(16)) bus ();

  serial_adder_ctrl #(.WIDTH(16)) u_dut (
    .i_EMUCLK (clk),
    .i_MRST_n (rst_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        id;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] s;
    logic        cout;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic drive(input logic id, input logic v,
                       input logic [15:0] a, input logic [15:0] b,
                       input logic cin, input logic sub);
    if (id) begin
      bus.i_REQ1_VALID = v;
      bus.i_REQ1_A = a;
      bus.i_REQ1_B = b;
      bus.i_REQ1_CIN = cin;
`ifdef SERIAL_ADDER_CTRL_SUB_EN
      bus.i_REQ1_SUB = sub;
`endif
    end else begin
      bus.i_REQ0_VALID = v;
      bus.i_REQ0_A = a;
      bus.i_REQ0_B = b;
      bus.i_REQ0_CIN = cin;
`ifdef SERIAL_ADDER_CTRL_SUB_EN
      bus.i_REQ0_SUB = sub;
`endif
    end
    if (sub === 1'bx) $display("bad sub");
  endtask

  // Ends #1 after the accept edge with VALID dropped.
  task automatic start_op(input vec_t v, input string nm);
    int n;
    logic rdy;
    @(negedge clk);
    drive(v.id, 1'b1, v.a, v.b, v.cin, v.sub);
    #1;
    n = 0;
    rdy = v.id ? bus.o_REQ1_READY : bus.o_REQ0_READY;
    while (!rdy && n < 20) begin
      @(negedge clk); #1; n++;
      rdy = v.id ? bus.o_REQ1_READY : bus.o_REQ0_READY;
    end
    chk({nm, "_ready"}, {31'd0, rdy}, 32'd1);
    @(posedge clk); #1;
    if (v.id) bus.i_REQ1_VALID = 1'b0;
    else      bus.i_REQ0_VALID = 1'b0;
  endtask

  // Counts edges after accept until VALID; 16 edges later = the 17th
  // edge counting the accept edge itself.
  task automatic wait_res(input vec_t v, input string nm);
    int n;
    n = 0;
    while (!bus.o_RES_VALID && n < 40) begin
      @(posedge clk); #1; n++;
    end
    chk({nm, "_lat"}, n, 32'd16);
    chk({nm, "_s"}, {16'd0, bus.o_RES_S}, {16'd0, v.s});
    chk({nm, "_cout"}, {31'd0, bus.o_RES_COUT}, {31'd0, v.cout});
    chk({nm, "_id"}, {31'd0, bus.o_RES_ID}, {31'd0, v.id});
  endtask

  function automatic vec_t mk(input logic id, input logic [15:0] a,
                              input logic [15:0] b, input logic cin,
                              input logic sub, input logic [15:0] s,
                              input logic cout);
    vec_t v;
    v.id = id; v.a = a; v.b = b; v.cin = cin;
    v.sub = sub; v.s = s; v.cout = cout;
    return v;
  endfunction

  initial begin
    int ids[4];
    int got;
    int both;
    int vcnt;
    logic [15:0] hs;
    logic hc;
    logic hi;
    vec_t v;

    tbl.push_back(mk(1'b0, 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0));
    tbl.push_back(mk(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1));
    tbl.push_back(mk(1'b1, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0));
    tbl.push_back(mk(1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1));
    tbl.push_back(mk(1'b1, 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1));
    tbl.push_back(mk(1'b0, 16'hABCD, 16'h1111, 1'b0, 1'b0, 16'hBCDE, 1'b0));
`ifdef SERIAL_ADDER_CTRL_SUB_EN
    tbl.push_back(mk(1'b0, 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0));
    tbl.push_back(mk(1'b1, 16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1));
`endif

    drive(1'b0, 1'b1, 16'h1, 16'h1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 16'h1, 16'h1, 1'b1, 1'b0);
    bus.i_RES_READY = 1'b1;
    #23;
    chk("reset_outs",
        {25'd0, bus.o_BUSY, bus.o_RES_VALID, bus.o_RES_COUT,
         bus.o_RES_ID, bus.o_REQ0_READY, bus.o_REQ1_READY, 1'b0},
        32'd0);
    chk("reset_s", {16'd0, bus.o_RES_S}, 32'd0);
    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      start_op(tbl[i], $sformatf("vec%0d", i));
      wait_res(tbl[i], $sformatf("vec%0d", i));
      @(posedge clk); #1;
      chk($sformatf("vec%0d_idle", i), {31'd0, bus.o_BUSY}, 32'd0);
    end

    // Result stall: DONE must hold everything while i_RES_READY is low.
    bus.i_RES_READY = 1'b0;
    v = mk(1'b0, 16'h2222, 16'h1357, 1'b0, 1'b0, 16'h3579, 1'b0);
    start_op(v, "stall");
    wait_res(v, "stall");
    hs = bus.o_RES_S; hc = bus.o_RES_COUT; hi = bus.o_RES_ID;
    drive(1'b0, 1'b1, 16'h0F0F, 16'h0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 16'hF0F0, 16'h0, 1'b0, 1'b0);
    both = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (bus.o_RES_S !== hs || bus.o_RES_COUT !== hc ||
          bus.o_RES_ID !== hi || bus.o_RES_VALID !== 1'b1 ||
          bus.o_REQ0_READY !== 1'b0 || bus.o_REQ1_READY !== 1'b0)
        both++;
    end
    chk("stall_hold", both, 32'd0);
    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    bus.i_RES_READY = 1'b1;
    @(posedge clk); #1;
    chk("stall_idle", {30'd0, bus.o_BUSY, bus.o_RES_VALID}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("idle_hold_s", {16'd0, bus.o_RES_S}, 32'h3579);

    // Round-robin from reset with both requesters always valid.
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) ids[k] = -1;
    got = 0;
    both = 0;
    drive(1'b0, 1'b1, 16'h0001, 16'h0001, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 16'h0003, 16'h0004, 1'b0, 1'b0);
    for (int c = 0; c < 200 && got < 4; c++) begin
      @(negedge clk); #1;
      if (bus.o_REQ0_READY && bus.o_REQ1_READY) both++;
      if (bus.o_RES_VALID) begin
        ids[got] = int'(bus.o_RES_ID);
        chk($sformatf("rr_s%0d", got), {16'd0, bus.o_RES_S},
            bus.o_RES_ID ? 32'd7 : 32'd2);
        got++;
        if (got == 4) begin
          drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
          drive(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        end
      end
    end
    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    chk("rr_both_ready", both, 32'd0);
    for (int k = 0; k < 4; k++)
      chk($sformatf("rr_id%0d", k), ids[k], k % 2);
    repeat (2) @(posedge clk);

    // Reset at counter=7 discards the operation in flight.
    v = mk(1'b1, 16'h7777, 16'h1111, 1'b0, 1'b0, 16'h8888, 1'b0);
    start_op(v, "rst_mid");
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    drive(1'b0, 1'b1, 16'h5, 16'h5, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 16'h5, 16'h5, 1'b0, 1'b0);
    #1;
    chk("rst_mid_outs",
        {26'd0, bus.o_BUSY, bus.o_RES_VALID, bus.o_RES_COUT,
         bus.o_RES_ID, bus.o_REQ0_READY, bus.o_REQ1_READY},
        32'd0);
    chk("rst_mid_s", {16'd0, bus.o_RES_S}, 32'd0);
    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    vcnt = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (bus.o_RES_VALID || bus.o_BUSY) vcnt++;
    end
    chk("rst_mid_no_res", vcnt, 32'd0);
    v = mk(1'b0, 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0);
    start_op(v, "post_rst");
    wait_res(v, "post_rst");
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 Parameter WIDTH SHALL default to 16 and set the operand/result width in bits; legal range is 2..32.
REQ-002 i_EMUCLK  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 i_MRST_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 i_REQ0_VALID / i_REQ1_VALID  input  1 each  SHALL flag a pending operation from requester 0 / 1.
REQ-005 o_REQ0_READY / o_REQ1_READY  output  1 each  SHALL flag acceptance of that requester's operands this cycle.
REQ-006 i_REQ0_A, i_REQ0_B, i_REQ1_A, i_REQ1_B  input  WIDTH each  SHALL carry the operands.
REQ-007 i_REQ0_CIN / i_REQ1_CIN  input  1 each  SHALL carry the carry-in.
REQ-008 o_RES_VALID  output  1  SHALL flag a valid result; i_RES_READY  input  1  SHALL accept it.
REQ-009 o_RES_S  output  WIDTH  SHALL carry the sum; o_RES_COUT  output  1  SHALL carry the final carry.
REQ-010 o_RES_ID  output  1  SHALL identify the requester that owns the result.
REQ-011 o_BUSY  output  1  SHALL be high in every state except IDLE.

Function
REQ-012 Controller SHALL time-share one 1-bit full-adder cell, LSB first, with a 1-bit carry register.
REQ-013 FSM SHALL have states IDLE, SHIFT and DONE.
REQ-014 In IDLE, READY SHALL be asserted combinationally only to the granted requester, and only when its VALID is high.
REQ-015 Grant SHALL be round-robin: when both are valid, the requester not granted last wins; with one valid, that requester wins.
REQ-016 On a VALID&READY edge, the controller SHALL latch A, B, CIN and ID, clear the bit counter and enter SHIFT.
REQ-017 Each SHIFT cycle SHALL add A[0], B[0] and the carry, shift the sum bit into the result MSB, shift A and B right, update the carry and increment the counter.
REQ-018 After exactly WIDTH SHIFT cycles, the FSM SHALL enter DONE; o_RES_VALID SHALL rise WIDTH+1 edges after the accept edge.
REQ-019 In DONE, o_RES_VALID, o_RES_S, o_RES_COUT and o_RES_ID SHALL stay stable until i_RES_READY is high, then the FSM SHALL return to IDLE on that edge.
REQ-020 READY SHALL be low in SHIFT and DONE; a new accept SHALL be possible no earlier than the first IDLE cycle.
REQ-021 Deassertion of VALID outside IDLE SHALL have no effect; the operation in flight SHALL complete.
REQ-022 o_RES_S and o_RES_COUT SHALL hold the last result in IDLE until the next accept.

Reset
REQ-023 With i_MRST_n low, the controller SHALL immediately enter IDLE, including mid-SHIFT or in DONE, and discard any in-flight operation.
REQ-024 With i_MRST_n low, all outputs SHALL be 0, the counter and carry SHALL be 0, and last-grant SHALL be 1 so requester 0 wins first.

Configuration
REQ-025 Macro SERIAL_ADDER_CTRL_SUB_EN SHALL add inputs i_REQ0_SUB and i_REQ1_SUB (1 bit each), latched with the operands.
REQ-026 With the macro defined and SUB=1, the controller SHALL compute A-B as A+~B+1, forcing carry-in to 1 and ignoring CIN; o_RES_COUT=1 SHALL mean no borrow.
REQ-027 With the macro undefined, the SUB ports SHALL be absent and the block SHALL be add-only.

Structure
REQ-028 Package serial_adder_ctrl_pkg SHALL hold the state enum typedef (IDLE/SHIFT/DONE) and the requester-ID constants.
REQ-029 The adder cell SHALL be one instance of the team's FA primitive; the arbiter, counter and shift registers SHALL be inline.

Verification
REQ-030 WIDTH=16, req0 A=0x1234 B=0x4321 CIN=0 -> S=0x5555 COUT=0 ID=0, with o_RES_VALID 17 edges after accept.
REQ-031 req1 A=0xFFFF B=0x0001 CIN=0 -> S=0x0000 COUT=1 ID=1; A=0x0000 B=0x0000 CIN=1 -> S=0x0001 COUT=0.
REQ-032 Both VALID held after reset -> results arrive with ID order 0,1,0,1, and READY is never high to both in one cycle.
REQ-033 i_RES_READY held low 5 cycles in DONE -> result bits stable and both READYs low throughout; IDLE on the cycle after i_RES_READY rises.
REQ-034 i_MRST_n pulsed low at SHIFT counter=7 -> all outputs 0 immediately, no result emitted; the next operation 0x00FF+0x0001 -> 0x0100.
REQ-035 With SERIAL_ADDER_CTRL_SUB_EN, SUB=1: A=0x0005 B=0x0007 -> S=0xFFFE COUT=0; A=0x0007 B=0x0005 -> S=0x0002 COUT=1.
